// File: rtl/msix_intr_gen_if.sv
// MSI-X DW memory-write channel: valid/ready handshake carrying address, data and vector index.
interface msix_intr_gen_if #(
   parameter int unsigned IDX_W = 3
);
   logic             wr_valid;
   logic             wr_ready;
   logic [63:0]      wr_addr;
   logic [31:0]      wr_data;
   logic [IDX_W-1:0] wr_vec;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      output wr_vec,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      input  wr_vec,
      output wr_ready
   );
endinterface

// File: rtl/msix_intr_gen.sv
// MSI-X message generator: vector table, pending-bit array, round-robin arbiter, one DW write each.
// Build option MSIX_COALESCE_EN adds a GAP state holding GAP_CYC idle cycles after every accept.
module msix_intr_gen #(
   parameter int unsigned NUM_VEC = 8,
   parameter int unsigned IDX_W   = $clog2(NUM_VEC),
   parameter int unsigned GAP_CYC = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_msix_enable,
   input  logic               i_func_mask,
   input  logic [NUM_VEC-1:0] i_intr_req,
   input  logic               i_tbl_wr_en,
   input  logic [IDX_W-1:0]   i_tbl_wr_idx,
   input  logic [63:0]        i_tbl_wr_addr,
   input  logic [31:0]        i_tbl_wr_data,
   input  logic               i_tbl_wr_mask,
   msix_intr_gen_if.master    io_wr,
   output logic [NUM_VEC-1:0] o_pending
);

   if (NUM_VEC < 2 || NUM_VEC > 32 || GAP_CYC < 1) begin : g_bad_param
      $error("msix_intr_gen: NUM_VEC must be 2..32 and GAP_CYC at least 1");
   end

   typedef enum logic [1:0] {
      StIdle,
      StIssue
`ifdef MSIX_COALESCE_EN
      , StGap
`endif
   } state_e;

`ifdef MSIX_COALESCE_EN
   localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   logic [GapW-1:0]    r_gap_cnt;
`endif

   state_e             r_state;
   logic [63:0]        r_tbl_addr [NUM_VEC];
   logic [31:0]        r_tbl_data [NUM_VEC];
   logic [NUM_VEC-1:0] r_tbl_mask;
   logic [NUM_VEC-1:0] r_pending;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic               r_wr_valid;
   logic [63:0]        r_wr_addr;
   logic [31:0]        r_wr_data;
   logic [IDX_W-1:0]   r_wr_vec;

   logic [NUM_VEC-1:0] w_elig;
   logic               w_grant_vld;
   logic [IDX_W-1:0]   w_grant_idx;
   logic [IDX_W-1:0]   w_cand;
   logic               w_accept;
   logic [NUM_VEC-1:0] w_clr;

   assign w_elig   = r_pending & ~r_tbl_mask & {NUM_VEC{i_msix_enable & ~i_func_mask}};
   assign w_accept = r_wr_valid & io_wr.wr_ready;
   assign w_clr    = w_accept ? (NUM_VEC'(1) << r_wr_vec) : '0;

   // First eligible vector at or after the RR pointer, wrapping to 0.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
         w_cand = IDX_W'((32'(r_rr_ptr) + i) % NUM_VEC);
         if (!w_grant_vld && w_elig[w_cand]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = w_cand;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int v = 0; v < NUM_VEC; v++) begin
            r_tbl_addr[v] <= '0;
            r_tbl_data[v] <= '0;
         end
         r_tbl_mask <= '1;
      end else if (i_tbl_wr_en && (32'(i_tbl_wr_idx) < NUM_VEC)) begin
         r_tbl_addr[i_tbl_wr_idx] <= {i_tbl_wr_addr[63:2], 2'b00};
         r_tbl_data[i_tbl_wr_idx] <= i_tbl_wr_data;
         r_tbl_mask[i_tbl_wr_idx] <= i_tbl_wr_mask;
      end
   end

   // A request arriving with the accept of its own vector keeps the bit set.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | i_intr_req;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_vec   <= '0;
         r_rr_ptr   <= '0;
`ifdef MSIX_COALESCE_EN
         r_gap_cnt  <= '0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_grant_vld) begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_tbl_addr[w_grant_idx];
                  r_wr_data  <= r_tbl_data[w_grant_idx];
                  r_wr_vec   <= w_grant_idx;
                  r_state    <= StIssue;
               end
            end
            StIssue: begin
               if (io_wr.wr_ready) begin
                  r_wr_valid <= 1'b0;
                  r_rr_ptr   <= IDX_W'((32'(r_wr_vec) + 1) % NUM_VEC);
`ifdef MSIX_COALESCE_EN
                  r_gap_cnt  <= '0;
                  r_state    <= StGap;
`else
                  r_state    <= StIdle;
`endif
               end
            end
`ifdef MSIX_COALESCE_EN
            StGap: begin
               if (r_gap_cnt == GapW'(GAP_CYC - 1)) begin
                  r_state <= StIdle;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GapW'(1);
               end
            end
`endif
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_wr.wr_valid = r_wr_valid;
   assign io_wr.wr_addr  = r_wr_addr;
   assign io_wr.wr_data  = r_wr_data;
   assign io_wr.wr_vec   = r_wr_vec;
   assign o_pending      = r_pending;

endmodule

// File: tb/tb_msix_intr_gen.sv
// Self-checking bench for msix_intr_gen: reset, table-driven arbitration rows, directed corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_msix_intr_gen;
   localparam int unsigned NV  = 8;
   localparam int unsigned IW  = 3;
   localparam int unsigned GAP = 16;
`ifdef MSIX_COALESCE_EN
   localparam int unsigned ExpGap = GAP + 2;
`else
   localparam int unsigned ExpGap = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en;
   logic          fmask;
   logic [NV-1:0] req;
   logic          tbl_en;
   logic [IW-1:0] tbl_idx;
   logic [63:0]   tbl_addr;
   logic [31:0]   tbl_data;
   logic          tbl_mask;
   logic [NV-1:0] pend;

   msix_intr_gen_if #(.IDX_W(IW)) wif ();

   msix_intr_gen #(.NUM_VEC(NV), .IDX_W(IW), .GAP_CYC(GAP)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_msix_enable (en),
      .i_func_mask   (fmask),
      .i_intr_req    (req),
      .i_tbl_wr_en   (tbl_en),
      .i_tbl_wr_idx  (tbl_idx),
      .i_tbl_wr_addr (tbl_addr),
      .i_tbl_wr_data (tbl_data),
      .i_tbl_wr_mask (tbl_mask),
      .io_wr         (wif),
      .o_pending     (pend)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [NV-1:0] req;
      logic          rdy;
      logic          en;
      logic          fm;
      logic          ev;
      int            evec;
      logic [NV-1:0] epend;
   } row_t;
   row_t rows [18];

   // Reference model state
   logic [NV-1:0] m_pend, m_mask, m_pend_n;
   logic [63:0]   m_taddr [NV];
   logic [31:0]   m_tdata [NV];
   logic [63:0]   m_oaddr;
   logic [31:0]   m_odata;
   bit            m_valid, m_found;
   int            m_vec, m_start, m_cool, m_v;
   int            cyc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tbl_wr(input int idx, input logic [63:0] a, input logic [31:0] d,
                         input logic m);
      tbl_en = 1'b1; tbl_idx = IW'(idx); tbl_addr = a; tbl_data = d; tbl_mask = m;
      tick();
      tbl_en = 1'b0;
   endtask

   task automatic wait_valid(input string nm, input int max, output int n);
      n = 0;
      while (!wif.wr_valid && n < max) begin
         tick();
         n++;
      end
      chk(nm, wif.wr_valid, 1'b1);
   endtask

   task automatic accept();
      wif.wr_ready = 1'b1;
      tick();
      wif.wr_ready = 1'b0;
   endtask

   function automatic logic [63:0] taddr(input int v);
      return 64'hFEE0_0000_0000_1000 + 64'(v) * 64'd16;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rows[0]  = '{8'h29, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h29};
      rows[1]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'h29};
      rows[2]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h28};
      rows[3]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3, 8'h28};
      rows[4]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h20};
      rows[5]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 5, 8'h20};
      rows[6]  = '{8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h09};
      rows[7]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'h09};
      rows[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h09};
      rows[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h08};
      rows[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3, 8'h08};
      rows[11] = '{8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h08};
      rows[12] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h08};
      rows[13] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h08};
      rows[14] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3, 8'h08};
      rows[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'h08};
      rows[16] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00};
      rows[17] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00};

      en = 1'b0; fmask = 1'b0; req = '0; tbl_en = 1'b0; tbl_idx = '0;
      tbl_addr = '0; tbl_data = '0; tbl_mask = 1'b0; wif.wr_ready = 1'b0;

      // Reset state
      #23;
      chk("reset wr_valid", wif.wr_valid, 1'b0);
      chk("reset wr_addr", wif.wr_addr, 64'h0);
      chk("reset wr_data", wif.wr_data, 32'h0);
      chk("reset wr_vec", wif.wr_vec, 3'h0);
      chk("reset pending", pend, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Masks come out of reset set: pending held, nothing issued
      en = 1'b1; req = 8'h01; tick(); req = '0;
      repeat (4) tick();
      chk("reset mask no write", wif.wr_valid, 1'b0);
      chk("reset mask pend kept", pend, 8'h01);
      #2 rst_n = 1'b0;
      #1 chk("async reset pending", pend, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Low address bits written as 1 must read back as 0
      for (int v = 0; v < NV; v++) tbl_wr(v, taddr(v) | 64'h3, 32'h100 + 32'(v), 1'b0);

`ifndef MSIX_COALESCE_EN
      for (int i = 0; i < 18; i++) begin
         req = rows[i].req; wif.wr_ready = rows[i].rdy; en = rows[i].en; fmask = rows[i].fm;
         tick();
         chk($sformatf("row%0d valid", i), wif.wr_valid, rows[i].ev);
         chk($sformatf("row%0d pending", i), pend, rows[i].epend);
         if (rows[i].ev) begin
            chk($sformatf("row%0d vec", i), wif.wr_vec, rows[i].evec);
            chk($sformatf("row%0d addr", i), wif.wr_addr, taddr(rows[i].evec));
            chk($sformatf("row%0d data", i), wif.wr_data, 32'h100 + 32'(rows[i].evec));
         end
      end
`endif
      req = '0; en = 1'b1; fmask = 1'b0; wif.wr_ready = 1'b0;

      // Basic issue, 5-cycle backpressure, table write to in-flight vector
      tbl_wr(2, 64'hFEE0_0000_0000_1008, 32'h0000_0042, 1'b0);
      req = 8'h04; tick(); req = '0;
      chk("tp1 pend set", pend[2], 1'b1);
      chk("tp1 no valid yet", wif.wr_valid, 1'b0);
      tick();
      chk("tp1 valid", wif.wr_valid, 1'b1);
      chk("tp1 addr", wif.wr_addr, 64'hFEE0_0000_0000_1008);
      chk("tp1 data", wif.wr_data, 32'h42);
      chk("tp1 vec", wif.wr_vec, 3'd2);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            tbl_en = 1'b1; tbl_idx = 3'd2; tbl_addr = 64'hFEE0_0000_0000_2007;
            tbl_data = 32'h99; tbl_mask = 1'b0;
         end
         tick();
         tbl_en = 1'b0;
         chk($sformatf("hold%0d valid", k), wif.wr_valid, 1'b1);
         chk($sformatf("hold%0d addr", k), wif.wr_addr, 64'hFEE0_0000_0000_1008);
         chk($sformatf("hold%0d data", k), wif.wr_data, 32'h42);
      end
      accept();
      chk("tp1 valid drop", wif.wr_valid, 1'b0);
      chk("tp1 pend clear", pend[2], 1'b0);
      repeat (3) tick();
      chk("tp1 single write", wif.wr_valid, 1'b0);
      req = 8'h04; tick(); req = '0;
      wait_valid("tp1 reissue", 40, cyc);
      chk("tp1 new addr", wif.wr_addr, 64'hFEE0_0000_0000_2004);
      chk("tp1 new data", wif.wr_data, 32'h99);
      accept();

      // Masked pending vector, then unmasked
      tbl_wr(4, taddr(4), 32'h104, 1'b1);
      req = 8'h10; tick(); req = '0;
      repeat (4) tick();
      chk("mask no write", wif.wr_valid, 1'b0);
      chk("mask pend kept", pend[4], 1'b1);
      tbl_wr(4, taddr(4), 32'h104, 1'b0);
      wait_valid("unmask issue", 40, cyc);
      chk("unmask vec", wif.wr_vec, 3'd4);
      chk("unmask addr", wif.wr_addr, taddr(4));
      accept();
      chk("unmask pend clear", pend[4], 1'b0);

      // Request in the same cycle as its own accept
      req = 8'h02; tick(); req = '0;
      wait_valid("rq1 first", 40, cyc);
      chk("rq1 first vec", wif.wr_vec, 3'd1);
      wif.wr_ready = 1'b1; req = 8'h02; tick(); wif.wr_ready = 1'b0; req = '0;
      chk("rq1 pend kept", pend[1], 1'b1);
      chk("rq1 valid drop", wif.wr_valid, 1'b0);
      wait_valid("rq1 second", 40, cyc);
      chk("rq1 second vec", wif.wr_vec, 3'd1);
      accept();
      chk("rq1 pend clear", pend[1], 1'b0);

      // Spacing between back-to-back writes
      req = 8'h03; tick(); req = '0;
      wait_valid("gap first", 40, cyc);
      wif.wr_ready = 1'b1;
      tick();
      cyc = 1;
      while (!wif.wr_valid && cyc < 60) begin
         tick();
         cyc++;
      end
      chk("gap cycles", cyc, ExpGap);
      tick();
      wif.wr_ready = 1'b0;
      chk("gap both served", pend[1:0], 2'b00);

      // Reset during ISSUE drops the write
      req = 8'h01; tick(); req = '0;
      wait_valid("rst mid valid", 40, cyc);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst mid valid", wif.wr_valid, 1'b0);
      chk("rst mid pending", pend, 8'h00);
      chk("rst mid addr", wif.wr_addr, 64'h0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) tick();
      chk("rst mid lost", wif.wr_valid, 1'b0);

      // Randomized traffic against the reference model
      m_pend = '0; m_mask = '1; m_valid = 1'b0; m_vec = 0; m_start = 0; m_cool = 0;
      m_oaddr = '0; m_odata = '0;
      for (int v = 0; v < NV; v++) begin
         m_taddr[v] = '0;
         m_tdata[v] = '0;
      end
      for (int c = 0; c < 3000; c++) begin
         chk("rnd valid", wif.wr_valid, m_valid);
         chk("rnd pending", pend, m_pend);
         if (m_valid) begin
            chk("rnd vec", wif.wr_vec, m_vec);
            chk("rnd addr", wif.wr_addr, m_oaddr);
            chk("rnd data", wif.wr_data, m_odata);
         end

         req = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
         wif.wr_ready = ($urandom_range(0, 2) != 0);
         en = ($urandom_range(0, 9) != 0);
         fmask = ($urandom_range(0, 9) == 0);
         tbl_en = ($urandom_range(0, 4) == 0);
         tbl_idx = IW'($urandom_range(0, NV - 1));
         tbl_addr = {$urandom, $urandom};
         tbl_data = $urandom;
         tbl_mask = ($urandom_range(0, 3) == 0);

         m_pend_n = m_pend | req;
         if (m_valid && wif.wr_ready && !req[m_vec]) m_pend_n[m_vec] = 1'b0;
         if (m_valid) begin
            if (wif.wr_ready) begin
               m_valid = 1'b0;
               m_start = (m_vec + 1) % NV;
               m_cool = ExpGap - 2;
            end
         end else if (m_cool > 0) begin
            m_cool--;
         end else if (en && !fmask) begin
            m_found = 1'b0;
            for (int k = 0; k < NV; k++) begin
               m_v = (m_start + k) % NV;
               if (!m_found && m_pend[m_v] && !m_mask[m_v]) begin
                  m_found = 1'b1;
                  m_valid = 1'b1;
                  m_vec = m_v;
                  m_oaddr = m_taddr[m_v];
                  m_odata = m_tdata[m_v];
               end
            end
         end
         m_pend = m_pend_n;
         if (tbl_en) begin
            m_taddr[tbl_idx] = {tbl_addr[63:2], 2'b00};
            m_tdata[tbl_idx] = tbl_data;
            m_mask[tbl_idx] = tbl_mask;
         end
         tick();
      end
      req = '0; tbl_en = 1'b0; wif.wr_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/msix_intr_gen.md
Name: msix_intr_gen

Overview:
- Synthesizable MSI-X message generator that sits directly upstream of the host interface model.
- Collects per-vector interrupt requests from device queues and holds a programmable vector table (address, data, mask).
- Arbitrates pending vectors and issues one DW memory-write per interrupt on a valid/ready write channel.
- The host side detects these writes as MSI-X triggers by matching the write address against its registered vector addresses.

Parameters:
- NUM_VEC, 8, number of MSI-X vectors (2..32).
- IDX_W, $clog2(NUM_VEC), vector index width.
- GAP_CYC, 16, minimum idle cycles between issued writes (used only with MSIX_COALESCE_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- msix_enable  in  1  global MSI-X enable; 0 blocks new issues.
- func_mask  in  1  function mask; 1 blocks new issues.
- intr_req  in  NUM_VEC  per-vector request pulse (level is treated as one pulse per cycle high).
- tbl_wr_en  in  1  vector table write strobe.
- tbl_wr_idx  in  IDX_W  table entry index.
- tbl_wr_addr  in  64  message address.
- tbl_wr_data  in  32  message data.
- tbl_wr_mask  in  1  per-vector mask bit.
- wr_valid  out  1  write request valid.
- wr_ready  in  1  host accepts write.
- wr_addr  out  64  DW write address.
- wr_data  out  32  DW write data.
- wr_vec  out  IDX_W  vector index of current write.
- pending  out  NUM_VEC  pending-bit array (PBA).

Behaviour:
- Reset (async, rst_n=0):
  - wr_valid=0, wr_addr=0, wr_data=0, wr_vec=0, pending=0.
  - Table addr/data=0, all vector masks=1, round-robin pointer=0, FSM=IDLE.
- Table write: on tbl_wr_en, entry tbl_wr_idx takes addr (bits[1:0] forced 0), data and mask on the next edge. Index >= NUM_VEC is ignored.
- Pending: intr_req[v]=1 at edge N sets pending[v] at N+1. Pending is set regardless of mask/enable state.
- Eligible vectors: pending & ~mask, and only while msix_enable=1 and func_mask=0.
- Arbitration: round-robin. Search starts at the index after the last granted vector and wraps NUM_VEC-1 -> 0.
- FSM states:
  - IDLE: if any vector is eligible, latch table addr/data of the granted vector into wr_addr/wr_data/wr_vec, assert wr_valid next cycle, go to ISSUE.
  - ISSUE: hold wr_valid and all payload stable until wr_ready=1. On acceptance, clear pending[wr_vec], deassert wr_valid, advance the RR pointer, go to IDLE (GAP with the feature enabled).
- Latency: intr_req at edge N -> pending at N+1 -> wr_valid at N+2 when eligible and idle. Back-to-back issue is possible at most every 2 cycles (valid is deasserted one cycle after each accept).
- Boundary cases:
  - intr_req[v] in the same cycle its write is accepted: pending[v] stays 1, so v is reissued later.
  - Repeated intr_req while pending: merged, one write.
  - Table write to the in-flight vector: issued payload is unchanged; the new value is used on the next issue.
  - Mask set, msix_enable dropped or func_mask raised during ISSUE: the current write completes, because valid never drops without ready.
  - Masked pending vector unmasked: issued normally.
  - All pending masked: FSM stays IDLE, pending is retained.
  - rst_n asserted mid-ISSUE: wr_valid drops immediately; the pending write is lost.

Optional Feature:
- MSIX_COALESCE_EN.
- Defined:
  - After each accepted write, the FSM enters GAP and counts GAP_CYC cycles before returning to IDLE.
  - Requests still set pending during GAP.
  - Reset clears the counter.
- Undefined: no GAP state; acceptance returns directly to IDLE.

Test Plan:
- Program vec 2 addr=0xFEE0_0000_0000_1008, data=0x0000_0042, mask=0; enable=1; pulse intr_req[2] -> wr_valid 2 cycles later with that addr/data and wr_vec=2; pending[2] clears after accept.
- Hold wr_ready=0 for 5 cycles during ISSUE -> wr_valid/addr/data stable all 5 cycles; exactly one accepted write.
- Pulse vecs 0, 3, 5 in the same cycle with wr_ready=1 -> writes issue in order 0, 3, 5; pulse 0 and 3 again -> next order 3 is skipped only if not pending, i.e. order follows RR from 6 wrapping: 0, 3.
- Vec 4 mask=1, pulse intr_req[4] -> no write, pending[4]=1; clear mask -> write issued for vec 4, pending[4]=0.
- intr_req[1] asserted in the same cycle its write is accepted -> pending[1] remains 1; a second write for vec 1 follows.
- With MSIX_COALESCE_EN and GAP_CYC=16, pulse vecs 0 and 1 together -> second wr_valid rises 18 cycles after the first accept. Without the macro -> 2 cycles after.
